pcs_tx_lane_unpacker: RTL and testbench

// - Parametrised successor to the fixed 32-bit MAC-to-byte path in front of the 8b/10b encoder.
// - Accepts MAC words of 1/2/4/8 valid bytes, selected per word at run time, with per-byte K flags.
// - Buffers words in a small FIFO and emits one byte plus its K flag per PCLK to the encoder.
// - Optionally inserts SKP ordered sets.

---
 rtl/pcs_tx_lane_unpacker_if.sv | 27 ++
 rtl/pcs_tx_lane_unpacker.sv | 210 +++++++++++++++++++++
 tb/tb_pcs_tx_lane_unpacker.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_tx_lane_unpacker_if.sv
// MAC-side word bus and encoder-side byte bus of the TX lane unpacker.
interface pcs_tx_lane_unpacker_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   MAC_TX_Data;
    logic [DATA_WIDTH/8-1:0] MAC_TX_Data_k;
    logic                    MAC_Data_En;
    logic [1:0]              Width_Mode;
    logic                    MAC_Ready;
    logic [7:0]              TxData;
    logic                    TxDataK;
    logic                    Encoder_en;
    logic                    Err_Width;
    logic                    Skp_Active;

    // MAC / test driver side
    modport master (
        output MAC_TX_Data, MAC_TX_Data_k, MAC_Data_En, Width_Mode,
        input  MAC_Ready, TxData, TxDataK, Encoder_en, Err_Width, Skp_Active
    );

    // Unpacker side
    modport slave (
        input  MAC_TX_Data, MAC_TX_Data_k, MAC_Data_En, Width_Mode,
        output MAC_Ready, TxData, TxDataK, Encoder_en, Err_Width, Skp_Active
    );
endinterface

// File: rtl/pcs_tx_lane_unpacker.sv
// TX lane unpacker: queues MAC words of 1/2/4/8 bytes and emits one byte
// plus K flag per PCLK towards the 8b/10b encoder.
// Optional SKP ordered-set insertion is built when PCS_TX_SKP_INSERT_EN is defined.
module pcs_tx_lane_unpacker #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic                    PCLK,
    input  logic                    RST_n,
    pcs_tx_lane_unpacker_if.slave   bus
);

    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned MAX_MODE = $clog2(BYTES);
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned REM_W    = $clog2(BYTES) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef PCS_TX_SKP_INSERT_EN
    localparam logic [1:0] ST_SKP   = 2'd2;
    localparam logic [7:0] COM_BYTE = 8'hBC;
    localparam logic [7:0] SKP_BYTE = 8'h1C;
`endif

    // Elaboration-time parameter sanity
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
        $error("DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (SKP_INTERVAL == 0 || SKP_INTERVAL > 65535) begin : g_bad_interval
        $error("SKP_INTERVAL must be 1..65535");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [BYTES-1:0]      k;
        logic [1:0]            mode;
    } entry_t;

    entry_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;
    logic [CNT_W-1:0]     fifo_cnt_n;
    logic                 push_c;
    logic                 pop_c;
    logic                 mode_ok_c;
    logic [1:0]           mode_wr_c;
    entry_t               head;

    logic [1:0]            state, state_n;
    logic [DATA_WIDTH-1:0] sh_data, sh_data_n;
    logic [BYTES-1:0]      sh_k, sh_k_n;
    logic [REM_W-1:0]      rem, rem_n;
    logic                  boundary_c;
    logic [7:0]            tx_data_n;
    logic                  tx_k_n;
    logic                  tx_en_n;
`ifdef PCS_TX_SKP_INSERT_EN
    logic [1:0]            skp_idx, skp_idx_n;
    logic [15:0]           skp_cnt, skp_cnt_n;
    logic                  skp_act_n;
`endif

    assign push_c     = bus.MAC_Data_En & bus.MAC_Ready;
    assign mode_ok_c  = (bus.Width_Mode <= 2'(MAX_MODE));
    assign mode_wr_c  = mode_ok_c ? bus.Width_Mode : 2'(MAX_MODE);
    assign head       = mem[rd_ptr];
    assign fifo_cnt_n = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);

    // Word storage; contents need no reset since the pointers are flushed
    always_ff @(posedge PCLK) begin
        if (push_c) begin
            mem[wr_ptr] <= '{data: bus.MAC_TX_Data, k: bus.MAC_TX_Data_k, mode: mode_wr_c};
        end
    end

    // FIFO pointers, registered ready and sticky width error
    always_ff @(posedge PCLK) begin
        if (!RST_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            bus.MAC_Ready <= 1'b0;
            bus.Err_Width <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt      <= fifo_cnt_n;
            bus.MAC_Ready <= (fifo_cnt_n != CNT_W'(FIFO_DEPTH));
            if (push_c && !mode_ok_c) begin
                bus.Err_Width <= 1'b1;
            end
        end
    end

    // Unpacker state register and registered encoder-side outputs
    always_ff @(posedge PCLK) begin
        if (!RST_n) begin
            state          <= ST_IDLE;
            sh_data        <= '0;
            sh_k           <= '0;
            rem            <= '0;
            bus.TxData     <= 8'h00;
            bus.TxDataK    <= 1'b0;
            bus.Encoder_en <= 1'b0;
`ifdef PCS_TX_SKP_INSERT_EN
            skp_idx        <= 2'd0;
            skp_cnt        <= 16'd0;
            bus.Skp_Active <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            sh_data        <= sh_data_n;
            sh_k           <= sh_k_n;
            rem            <= rem_n;
            bus.TxData     <= tx_data_n;
            bus.TxDataK    <= tx_k_n;
            bus.Encoder_en <= tx_en_n;
`ifdef PCS_TX_SKP_INSERT_EN
            skp_idx        <= skp_idx_n;
            skp_cnt        <= skp_cnt_n;
            bus.Skp_Active <= skp_act_n;
`endif
        end
    end

`ifndef PCS_TX_SKP_INSERT_EN
    assign bus.Skp_Active = 1'b0;
`endif

    // Next state: emit a byte per cycle; at word boundaries insert SKP or pop the next word
    always_comb begin
        state_n    = state;
        sh_data_n  = sh_data;
        sh_k_n     = sh_k;
        rem_n      = rem;
        pop_c      = 1'b0;
        boundary_c = 1'b0;
        tx_data_n  = 8'h00;
        tx_k_n     = 1'b0;
        tx_en_n    = 1'b0;
`ifdef PCS_TX_SKP_INSERT_EN
        skp_idx_n  = skp_idx;
        skp_cnt_n  = skp_cnt;
        skp_act_n  = 1'b0;
`endif
        case (state)
            ST_IDLE: boundary_c = 1'b1;
            ST_SHIFT: begin
                tx_data_n = sh_data[7:0];
                tx_k_n    = sh_k[0];
                tx_en_n   = 1'b1;
`ifdef PCS_TX_SKP_INSERT_EN
                skp_cnt_n = (skp_cnt == 16'hFFFF) ? skp_cnt : skp_cnt + 16'd1;
`endif
                if (rem == '0) begin
                    boundary_c = 1'b1;
                end else begin
                    sh_data_n = sh_data >> 8;
                    sh_k_n    = sh_k >> 1;
                    rem_n     = rem - REM_W'(1);
                end
            end
`ifdef PCS_TX_SKP_INSERT_EN
            ST_SKP: begin
                tx_data_n = (skp_idx == 2'd0) ? COM_BYTE : SKP_BYTE;
                tx_k_n    = 1'b1;
                tx_en_n   = 1'b1;
                skp_act_n = 1'b1;
                if (skp_idx == 2'd3) begin
                    skp_cnt_n  = 16'd0;
                    boundary_c = 1'b1;
                end else begin
                    skp_idx_n = skp_idx + 2'd1;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase

        if (boundary_c) begin
`ifdef PCS_TX_SKP_INSERT_EN
            if (skp_cnt_n >= 16'(SKP_INTERVAL)) begin
                state_n   = ST_SKP;
                skp_idx_n = 2'd0;
            end else
`endif
            if (fifo_cnt != '0) begin
                pop_c     = 1'b1;
                sh_data_n = head.data;
                sh_k_n    = head.k;
                rem_n     = REM_W'((32'd1 << head.mode) - 32'd1);
                state_n   = ST_SHIFT;
            end else begin
                state_n = ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pcs_tx_lane_unpacker.sv
// Self-checking bench for pcs_tx_lane_unpacker: directed vector table,
// back-pressure / mid-stream reset sequences and randomized traffic
// checked against a byte-stream reference model.
module tb_pcs_tx_lane_unpacker;

    localparam int unsigned DW      = 32;
    localparam int unsigned NB      = DW / 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned SKP_INT = 8;

    typedef struct {
        logic [7:0] data;
        logic       k;
        logic       skp;
    } obs_t;

    typedef struct {
        logic          en;
        logic [1:0]    mode;
        logic [DW-1:0] data;
        logic [NB-1:0] k;
        logic          exp_en;
        logic [7:0]    exp_data;
        logic          exp_k;
        logic          exp_rdy;
        logic          exp_err;
    } vec_t;

    logic PCLK = 1'b0;
    logic RST_n;

    pcs_tx_lane_unpacker_if #(.DATA_WIDTH(DW)) bus ();

    pcs_tx_lane_unpacker #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .SKP_INTERVAL(SKP_INT)
    ) dut (
        .PCLK (PCLK),
        .RST_n(RST_n),
        .bus  (bus)
    );

    always #5 PCLK = ~PCLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    obs_t        got[$];
    obs_t        exp_q[$];
    int unsigned got_cyc[$];
    int          model_cnt = 0;
    bit          model_err = 1'b0;
    bit          ready_low_seen = 1'b0;
    bit          abort = 1'b0;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Output monitor, sampled away from the active edge
    always @(negedge PCLK) begin
        if (RST_n && !bus.MAC_Ready) ready_low_seen = 1'b1;
        if (bus.Encoder_en === 1'b1) begin
            got.push_back('{bus.TxData, bus.TxDataK, bus.Skp_Active});
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected finish", 0);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference model: a word becomes its first 1<<mode bytes (clamped), low byte first
    task automatic model_word(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic [1:0] mode);
        int nbytes;
        nbytes = 1 << mode;
        if (nbytes > int'(NB)) begin
            nbytes    = int'(NB);
            model_err = 1'b1;
        end
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back('{d[8*i +: 8], k[i], 1'b0});
            model_cnt++;
        end
`ifdef PCS_TX_SKP_INSERT_EN
        if (model_cnt >= int'(SKP_INT)) begin
            exp_q.push_back('{8'hBC, 1'b1, 1'b1});
            repeat (3) exp_q.push_back('{8'h1C, 1'b1, 1'b1});
            model_cnt = 0;
        end
`endif
    endtask

    // Present a word and hold it until the handshake completes
    task automatic send_word(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic [1:0] mode);
        bit rdy;
        bit ok;
        ok = 1'b0;
        bus.MAC_TX_Data   = d;
        bus.MAC_TX_Data_k = k;
        bus.Width_Mode    = mode;
        bus.MAC_Data_En   = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (abort) break;
            rdy = bus.MAC_Ready;
            @(negedge PCLK);
            if (rdy && !abort) begin
                ok = 1'b1;
                model_word(d, k, mode);
                break;
            end
        end
        bus.MAC_Data_En = 1'b0;
        if (!ok && !abort) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: word 0x%0h not accepted, expected acceptance", d);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge PCLK);
        RST_n           = 1'b0;
        bus.MAC_Data_En = 1'b0;
        repeat (n) @(negedge PCLK);
        RST_n = 1'b1;
        @(negedge PCLK);
        got.delete();
        got_cyc.delete();
        exp_q.delete();
        model_cnt = 0;
        model_err = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (got.size() < exp_q.size() && t < 5000) begin
            @(negedge PCLK);
            t++;
        end
        repeat (10) @(negedge PCLK);
    endtask

    task automatic compare_streams(input string name);
        int n;
        check({name, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", name, i),
                  64'({got[i].skp, got[i].k, got[i].data}),
                  64'({exp_q[i].skp, exp_q[i].k, exp_q[i].data}));
        end
    endtask

    task automatic check_no_gaps(input string name);
        int gaps;
        gaps = 0;
        for (int i = 1; i < got_cyc.size(); i++) begin
            if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
        end
        check(name, 64'(gaps), 64'd0);
    endtask

`ifndef PCS_TX_SKP_INSERT_EN
    function automatic vec_t mk(input logic en, input logic [1:0] mode, input logic [DW-1:0] data,
                                input logic [NB-1:0] k, input logic een, input logic [7:0] ed,
                                input logic ek, input logic erdy, input logic eerr);
        vec_t v;
        v.en = en; v.mode = mode; v.data = data; v.k = k;
        v.exp_en = een; v.exp_data = ed; v.exp_k = ek; v.exp_rdy = erdy; v.exp_err = eerr;
        return v;
    endfunction

    // Cycle-exact vectors: latency, no-bubble mode 0, underrun zeros, illegal mode clamp
    task automatic run_table();
        vec_t v [23];
        v[0]  = mk(1'b1, 2'd2, 32'h44332211, 4'h1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        v[1]  = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        v[2]  = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
        v[3]  = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        v[4]  = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        v[5]  = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
        v[6]  = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        v[7]  = mk(1'b1, 2'd0, 32'hFFFFFFA1, 4'hE, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        v[8]  = mk(1'b1, 2'd0, 32'hFFFFFFA2, 4'hE, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        v[9]  = mk(1'b1, 2'd0, 32'hFFFFFFA3, 4'hF, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
        v[10] = mk(1'b1, 2'd0, 32'hFFFFFFA4, 4'hE, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
        v[11] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0);
        v[12] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'hA4, 1'b0, 1'b1, 1'b0);
        v[13] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        v[14] = mk(1'b1, 2'd3, 32'h88776655, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        v[15] = mk(1'b1, 2'd1, 32'h5566BBAA, 4'h2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        v[16] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        v[17] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b1);
        v[18] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        v[19] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'h88, 1'b0, 1'b1, 1'b1);
        v[20] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
        v[21] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b1);
        v[22] = mk(1'b0, 2'd0, 32'h0,        4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 23; i++) begin
            bus.MAC_Data_En   = v[i].en;
            bus.Width_Mode    = v[i].mode;
            bus.MAC_TX_Data   = v[i].data;
            bus.MAC_TX_Data_k = v[i].k;
            @(negedge PCLK);
            bus.MAC_Data_En = 1'b0;
            check($sformatf("tbl%0d_en", i),   64'(bus.Encoder_en), 64'(v[i].exp_en));
            check($sformatf("tbl%0d_data", i), 64'(bus.TxData),     64'(v[i].exp_data));
            check($sformatf("tbl%0d_k", i),    64'(bus.TxDataK),    64'(v[i].exp_k));
            check($sformatf("tbl%0d_rdy", i),  64'(bus.MAC_Ready),  64'(v[i].exp_rdy));
            check($sformatf("tbl%0d_err", i),  64'(bus.Err_Width),  64'(v[i].exp_err));
        end
    endtask
`else
    // Interval 8 with mode 2: two words, then COM + 3 SKP, then the third word
    task automatic run_skp_directed();
        logic [9:0] e [16];
        e[0]  = 10'h001; e[1]  = 10'h002; e[2]  = 10'h003; e[3]  = 10'h004;
        e[4]  = 10'h005; e[5]  = 10'h006; e[6]  = 10'h007; e[7]  = 10'h008;
        e[8]  = 10'h3BC; e[9]  = 10'h31C; e[10] = 10'h31C; e[11] = 10'h31C;
        e[12] = 10'h009; e[13] = 10'h00A; e[14] = 10'h00B; e[15] = 10'h00C;
        send_word(32'h04030201, 4'h0, 2'd2);
        send_word(32'h08070605, 4'h0, 2'd2);
        send_word(32'h0C0B0A09, 4'h0, 2'd2);
        wait_drain();
        check("skp_len", 64'(got.size()), 64'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            check($sformatf("skp_byte%0d", i), 64'({got[i].skp, got[i].k, got[i].data}), 64'(e[i]));
        end
        check_no_gaps("skp_gaps");
    endtask
`endif

    initial begin
        RST_n             = 1'b0;
        bus.MAC_Data_En   = 1'b1;
        bus.MAC_TX_Data   = 32'hDEADBEEF;
        bus.MAC_TX_Data_k = 4'hF;
        bus.Width_Mode    = 2'd2;

        // Reset held 3 cycles with a word offered
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check($sformatf("rst%0d_data", i), 64'(bus.TxData), 64'd0);
            check($sformatf("rst%0d_en", i),   64'(bus.Encoder_en), 64'd0);
            check($sformatf("rst%0d_rdy", i),  64'(bus.MAC_Ready), 64'd0);
            check($sformatf("rst%0d_err", i),  64'(bus.Err_Width), 64'd0);
            check($sformatf("rst%0d_skp", i),  64'(bus.Skp_Active), 64'd0);
        end
        RST_n           = 1'b1;
        bus.MAC_Data_En = 1'b0;
        @(negedge PCLK);
        check("rel_rdy", 64'(bus.MAC_Ready), 64'd1);
        repeat (5) @(negedge PCLK);
        check("rel_no_bytes", 64'(got.size()), 64'd0);

`ifndef PCS_TX_SKP_INSERT_EN
        run_table();
`else
        do_reset(2);
        run_skp_directed();
`endif

        // Back-pressure: 12 mode-2 words back to back
        do_reset(2);
        ready_low_seen = 1'b0;
        for (int w = 0; w < 12; w++) begin
            send_word($urandom, 4'($urandom), 2'd2);
        end
        wait_drain();
        compare_streams("bp");
        check("bp_ready_dropped", 64'(ready_low_seen), 64'd1);
        check_no_gaps("bp_gaps");

        // Same traffic with a reset landing on byte 2 of word 5
        do_reset(2);
        abort = 1'b0;
        fork
            begin
                for (int w = 0; w < 12; w++) begin
                    if (abort) break;
                    send_word($urandom, 4'($urandom), 2'd2);
                end
            end
            begin
                int t;
                t = 0;
                while (got.size() < 23 && t < 500) begin
                    @(negedge PCLK);
                    #1;
                    t++;
                end
                check("mid_trigger", 64'(got.size() >= 23), 64'd1);
                abort           = 1'b1;
                bus.MAC_Data_En = 1'b0;
                RST_n           = 1'b0;
            end
        join
        for (int i = 0; i < 23 && i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("mid_byte%0d", i),
                  64'({got[i].skp, got[i].k, got[i].data}),
                  64'({exp_q[i].skp, exp_q[i].k, exp_q[i].data}));
        end
        repeat (3) @(negedge PCLK);
        check("mid_rst_en", 64'(bus.Encoder_en), 64'd0);
        RST_n = 1'b1;
        abort = 1'b0;
        @(negedge PCLK);
        got.delete();
        got_cyc.delete();
        exp_q.delete();
        model_cnt = 0;
        model_err = 1'b0;
        repeat (30) @(negedge PCLK);
        check("mid_after_bytes", 64'(got.size()), 64'd0);
        check("mid_after_rdy", 64'(bus.MAC_Ready), 64'd1);

        // Randomized traffic: pass 0 legal modes only, pass 1 includes the illegal mode
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(2);
            for (int w = 0; w < 200; w++) begin
                send_word($urandom, 4'($urandom), 2'($urandom_range(0, (pass == 0) ? 2 : 3)));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge PCLK);
            end
            wait_drain();
            compare_streams($sformatf("rnd%0d", pass));
            check($sformatf("rnd%0d_err", pass), 64'(bus.Err_Width), 64'(model_err));
            check($sformatf("rnd%0d_idle_en", pass), 64'(bus.Encoder_en), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
